// File: rtl/life_keys_pkg.sv
// rtl/life_keys_pkg.sv - key codes and priority encoder shared by the life board key logic
//
// Purpose : 3-bit key codes carried on the keys bus (code = button index + 1)
//           and the lowest-index-wins priority encoder.
// Ports   : none (package)
package life_keys_pkg;

  typedef logic [2:0] key_t;

  localparam key_t KEY_NONE  = 3'd0;
  localparam key_t KEY_UP    = 3'd1;
  localparam key_t KEY_DOWN  = 3'd2;
  localparam key_t KEY_LEFT  = 3'd3;
  localparam key_t KEY_RIGHT = 3'd4;
  localparam key_t KEY_FLIP  = 3'd5;
  localparam key_t KEY_STEP  = 3'd6;
  localparam key_t KEY_RUN   = 3'd7;

  // Lowest set bit wins; scanning downwards lets the lowest index overwrite.
  function automatic key_t prio_encode(input logic [6:0] btn);
    key_t code;
    code = KEY_NONE;
    for (int i = 6; i >= 0; i--) begin
      if (btn[i]) code = key_t'(i + 1);
    end
    return code;
  endfunction

endpackage

// File: rtl/life_sync2.sv
// rtl/life_sync2.sv - parameterised-width 2-flop synchroniser
//
// Purpose : brings asynchronous inputs into the clk domain.
// Ports   : clk    - destination clock
//           rst_n  - asynchronous active-low reset, flops load RST_VAL
//           i_d    - asynchronous input bus
//           o_q    - synchronised output bus
module life_sync2 #(
  parameter int             W       = 1,
  parameter logic [W-1:0]   RST_VAL = '1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/life_keys.sv
// rtl/life_keys.sv - front-panel key encoder: sync, debounce, priority encode, auto-repeat
//
// Purpose : turns the raw active-low panel buttons into one-clock key-code
//           strobes; cursor keys auto-repeat while held.
// Ports   : clk    - system clock
//           reset  - asynchronous active-low reset
//           btn_n  - raw buttons, active-low, asynchronous to clk
//           keys   - registered one-clock key-code strobe, KEY_NONE otherwise
module life_keys
  import life_keys_pkg::*;
#(
  parameter int         PRE_W      = 12,
  parameter int         DEB_TICKS  = 4,
  parameter int         REP_DELAY  = 32,
  parameter int         REP_PERIOD = 8,
  parameter int         CNT_W      = 6,
  parameter logic [6:0] REP_MASK   = 7'b0001111
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] btn_n,
  output logic [2:0] keys
);

  localparam int CNT_MAX = (1 << CNT_W) - 1;

  if (PRE_W < 1) begin : g_chk_pre
    $error("life_keys: PRE_W must be >= 1");
  end
  if (DEB_TICKS < 2) begin : g_chk_deb
    $error("life_keys: DEB_TICKS must be >= 2");
  end
  if (REP_PERIOD < 1 || REP_DELAY < 1) begin : g_chk_rep
    $error("life_keys: REP_DELAY and REP_PERIOD must be >= 1");
  end
  if (DEB_TICKS > CNT_MAX || REP_DELAY > CNT_MAX || REP_PERIOD > CNT_MAX) begin : g_chk_cnt
    $error("life_keys: CNT_W too narrow for DEB_TICKS/REP_DELAY/REP_PERIOD");
  end

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2,
    ST_RELEASE  = 2'd3
  } state_t;

  // Bit 7 pads the mask so r_cur-1 is always a legal index (r_cur==0 -> 7).
  localparam logic [7:0] REP_MASK_X = {1'b0, REP_MASK};

  state_t           r_state, w_state_nxt;
  key_t             r_cur, w_cur_nxt;
  key_t             r_keys;
  key_t             w_cand;
  logic [CNT_W-1:0] r_deb, w_deb_nxt, w_deb_inc;
  logic [CNT_W-1:0] r_rep, w_rep_nxt, w_rep_dec;
  logic [PRE_W-1:0] r_pre;
  logic [6:0]       w_btn_sync;
  logic [6:0]       w_btn_s;
  logic             w_tick;
  logic             w_strobe;
  logic             w_rep_en;

  life_sync2 #(.W(7), .RST_VAL(7'h7f)) u_sync (
    .clk   (clk),
    .rst_n (reset),
    .i_d   (btn_n),
    .o_q   (w_btn_sync)
  );

  assign w_btn_s   = ~w_btn_sync;
  assign w_cand    = prio_encode(w_btn_s);
  assign w_tick    = &r_pre;
  assign w_deb_inc = r_deb + CNT_W'(1);
  assign w_rep_dec = r_rep - CNT_W'(1);
  assign w_rep_en  = REP_MASK_X[r_cur - 3'd1];

  always_comb begin
    w_state_nxt = r_state;
    w_cur_nxt   = r_cur;
    w_deb_nxt   = r_deb;
    w_rep_nxt   = r_rep;
    w_strobe    = 1'b0;
    if (w_tick) begin
      case (r_state)
        ST_IDLE: begin
          if (w_cand != KEY_NONE) begin
            w_cur_nxt   = w_cand;
            w_deb_nxt   = CNT_W'(1);
            w_state_nxt = ST_DEBOUNCE;
          end
        end
        ST_DEBOUNCE: begin
          if (w_cand == r_cur) begin
            w_deb_nxt = w_deb_inc;
            if (w_deb_inc == CNT_W'(DEB_TICKS)) begin
              w_strobe    = 1'b1;
              w_rep_nxt   = CNT_W'(REP_DELAY);
              w_state_nxt = ST_HELD;
            end
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_HELD: begin
          if (w_cand == r_cur) begin
            if (w_rep_en) begin
              w_rep_nxt = w_rep_dec;
              if (w_rep_dec == '0) begin
                w_strobe  = 1'b1;
                w_rep_nxt = CNT_W'(REP_PERIOD);
              end
            end
          end else begin
            w_deb_nxt   = '0;
            w_state_nxt = ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (w_cand == KEY_NONE) begin
            w_deb_nxt = w_deb_inc;
            if (w_deb_inc == CNT_W'(DEB_TICKS)) w_state_nxt = ST_IDLE;
          end else if (w_cand == r_cur) begin
            // Bounce on the held key: resume repeating where it left off.
            w_state_nxt = ST_HELD;
          end else begin
            // A different key while releasing restarts the release count,
            // so nothing new is accepted until every button is up.
            w_deb_nxt = '0;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pre   <= '0;
      r_state <= ST_IDLE;
      r_cur   <= KEY_NONE;
      r_deb   <= '0;
      r_rep   <= '0;
      r_keys  <= KEY_NONE;
    end else begin
      r_pre   <= r_pre + PRE_W'(1);
      r_state <= w_state_nxt;
      r_cur   <= w_cur_nxt;
      r_deb   <= w_deb_nxt;
      r_rep   <= w_rep_nxt;
      r_keys  <= w_strobe ? r_cur : KEY_NONE;
    end
  end

  assign keys = r_keys;

endmodule

// File: tb/tb_life_keys.sv
// tb/tb_life_keys.sv - self-checking bench for life_keys against a tick-level reference model
`timescale 1ns/1ps
module tb_life_keys;

  localparam int         PRE_W = 2;
  localparam int         DEB   = 3;
  localparam int         RDLY  = 5;
  localparam int         RPER  = 2;
  localparam logic [6:0] RMASK = 7'b0001111;
  localparam int         TCLK  = 1 << PRE_W;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] btn_n = 7'h7f;
  logic [2:0] keys;

  int checks = 0;
  int errors = 0;

  life_keys #(
    .PRE_W(PRE_W), .DEB_TICKS(DEB), .REP_DELAY(RDLY), .REP_PERIOD(RPER),
    .CNT_W(6), .REP_MASK(RMASK)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .btn_n (btn_n),
    .keys  (keys)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model (per-tick key behaviour) ----------------
  logic [6:0] rep_mask = RMASK;
  logic [6:0] m_s1, m_s2;
  int  m_phase, m_key, m_run, m_since, exp_keys;
  bit  m_locked, m_releasing, m_first;

  function automatic int lowest_code(input logic [6:0] pressed);
    for (int i = 0; i < 7; i++) if (pressed[i]) return i + 1;
    return 0;
  endfunction

  task automatic model_reset();
    m_s1 = 7'h7f; m_s2 = 7'h7f; m_phase = 0;
    m_key = 0; m_run = 0; m_since = 0; exp_keys = 0;
    m_locked = 0; m_releasing = 0; m_first = 0;
  endtask

  // m_key: key being tracked (0 = none); m_locked: press accepted;
  // m_since: held ticks since last strobe; m_releasing: waiting for all-up.
  task automatic model_tick(input int c, output int strobe);
    strobe = 0;
    if (m_key == 0) begin
      if (c != 0) begin m_key = c; m_run = 1; m_locked = 0; end
    end else if (!m_locked) begin
      if (c == m_key) begin
        m_run++;
        if (m_run == DEB) begin
          strobe = m_key; m_locked = 1; m_releasing = 0; m_since = 0; m_first = 1;
        end
      end else m_key = 0;
    end else if (!m_releasing) begin
      if (c == m_key) begin
        if (rep_mask[m_key-1]) begin
          m_since++;
          if (m_since == (m_first ? RDLY : RPER)) begin
            strobe = m_key; m_since = 0; m_first = 0;
          end
        end
      end else begin
        m_releasing = 1; m_run = 0;
      end
    end else begin
      if (c == 0) begin
        m_run++;
        if (m_run == DEB) begin m_key = 0; m_locked = 0; m_releasing = 0; end
      end else if (c == m_key) m_releasing = 0;
      else m_run = 0;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) model_reset();
      else begin
        int s;
        s = 0;
        if (m_phase == TCLK - 1) model_tick(lowest_code(~m_s2), s);
        exp_keys = s;
        m_s2 = m_s1;
        m_s1 = btn_n;
        m_phase = (m_phase + 1) % TCLK;
      end
    end
  end

  // ---------------- monitor: every cycle against the model ----------------
  int         strobe_cnt = 0;
  logic [2:0] last_code  = 3'd0;

  initial forever begin
    @(negedge clk);
    check_eq("keys_vs_model", keys, exp_keys);
    if (keys != 3'd0) begin
      strobe_cnt++;
      last_code = keys;
    end
  end

  // ---------------- stimulus ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ticks(input int n);
    cycles(n * TCLK);
  endtask

  task automatic release_and_settle();
    btn_n = 7'h7f;
    ticks(DEB + 3);
  endtask

  // Call at the negedge where reset was released; measures clocks to the first strobe.
  task automatic measure_first(input string tag, input int code);
    int lat;
    lat = -1;
    for (int i = 1; i <= 64; i++) begin
      @(negedge clk);
      if (keys == code[2:0]) begin lat = i; break; end
    end
    check_eq(tag, lat, DEB * TCLK);
  endtask

  initial begin
    int s0, hits, found;
    logic [6:0] pat;

    // 1: button 0 held across reset release
    btn_n = 7'b1111110;
    #2 reset = 1'b0;
    cycles(3);
    check_eq("t1_reset_keys", keys, 0);
    reset = 1'b1;
    measure_first("t1_first_latency", 1);
    release_and_settle();

    // 2: FLIP held 100 ticks, non-repeating
    s0 = strobe_cnt;
    btn_n = ~(7'b1 << 4);
    ticks(100);
    release_and_settle();
    check_eq("t2_flip_count", strobe_cnt - s0, 1);
    check_eq("t2_flip_code", last_code, 5);

    // 3: bouncing button 2 never strobes
    s0 = strobe_cnt;
    for (int i = 0; i < 10; i++) begin
      btn_n[2] = ~btn_n[2];
      ticks(1);
    end
    release_and_settle();
    check_eq("t3_bounce_count", strobe_cnt - s0, 0);

    // 4: UP held 20 ticks -> strobes at ticks 3,8,10,...,20
    s0 = strobe_cnt;
    btn_n = 7'b1111110;
    ticks(20);
    btn_n = 7'h7f;
    ticks(1);
    btn_n = 7'b1111110;
    ticks(6);
    release_and_settle();
    check_eq("t4_up_repeat_count_min", (strobe_cnt - s0) >= 8, 1);

    // 4b: FLIP released for one tick then re-pressed is one press
    s0 = strobe_cnt;
    btn_n = ~(7'b1 << 4);
    ticks(10);
    btn_n = 7'h7f;
    ticks(1);
    btn_n = ~(7'b1 << 4);
    ticks(10);
    release_and_settle();
    check_eq("t4_flip_glitch_count", strobe_cnt - s0, 1);

    // 5: buttons 1 and 3 together -> DOWN only; RIGHT needs a full release
    s0 = strobe_cnt;
    btn_n = ~7'b0001010;
    ticks(5);
    check_eq("t5_pair_count", strobe_cnt - s0, 1);
    check_eq("t5_pair_code", last_code, 2);
    s0 = strobe_cnt;
    btn_n = ~7'b0001000;
    ticks(10);
    check_eq("t5_second_blocked", strobe_cnt - s0, 0);
    btn_n = 7'h7f;
    ticks(DEB + 2);
    btn_n = ~7'b0001000;
    ticks(5);
    check_eq("t5_right_count", strobe_cnt - s0, 1);
    check_eq("t5_right_code", last_code, 4);
    release_and_settle();

    // 6: reset asserted on a repeat strobe
    btn_n = 7'b1111110;
    hits = 0;
    found = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (keys != 3'd0) hits++;
      if (hits >= 2) begin found = 1; break; end
    end
    check_eq("t6_repeat_seen", found, 1);
    #1 reset = 1'b0;
    #1 check_eq("t6_async_reset", keys, 0);
    cycles(2);
    reset = 1'b1;
    measure_first("t6_first_after_reset", 1);
    release_and_settle();

    // Randomised patterns and hold lengths, phase-shifted against the prescaler
    for (int seg = 0; seg < 60; seg++) begin
      int r;
      r = $urandom_range(0, 9);
      pat = 7'd0;
      if (r >= 2) pat[$urandom_range(0, 6)] = 1'b1;
      if (r >= 8) pat[$urandom_range(0, 6)] = 1'b1;
      btn_n = ~pat;
      cycles($urandom_range(1, 12 * TCLK));
    end
    release_and_settle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
